// File: rtl/pipe_pkg.sv
// Shared opcodes, FSM encodings and control bundle
// for the pipeline hazard controller.
package pipe_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LOAD = 8'h40;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2,
      ST_BAD   = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic pc_sel;
      logic buf1_en;
      logic buf1_bubble;
      logic buf2_bubble;
   } hz_ctl_t;

   // Free-running pipeline, nothing to suppress.
   localparam hz_ctl_t CTL_RUN = '{
      pc_en:       1'b1,
      pc_sel:      1'b0,
      buf1_en:     1'b1,
      buf1_bubble: 1'b0,
      buf2_bubble: 1'b0
   };

   // Redirect fetch and squash both younger slots.
   localparam hz_ctl_t CTL_FLUSH = '{
      pc_en:       1'b1,
      pc_sel:      1'b1,
      buf1_en:     1'b1,
      buf1_bubble: 1'b1,
      buf2_bubble: 1'b1
   };

   // Hold front end, inject a bubble behind decode.
   localparam hz_ctl_t CTL_FREEZE = '{
      pc_en:       1'b0,
      pc_sel:      1'b0,
      buf1_en:     1'b0,
      buf1_bubble: 1'b0,
      buf2_bubble: 1'b1
   };

   // Everything quiet while reset is asserted.
   localparam hz_ctl_t CTL_RESET = '{
      pc_en:       1'b0,
      pc_sel:      1'b0,
      buf1_en:     1'b0,
      buf1_bubble: 1'b1,
      buf2_bubble: 1'b1
   };

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 8'hFF,
// with synchronous clear.
module sat_cnt8 (
   input  logic       clk,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] q
);

   // Count up on inc, never wrapping past all-ones.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= 8'h00;
      end else if (inc && (q != 8'hFF)) begin
         q <= q + 8'h01;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 4-stage pipe: halt,
// branch flush and load-use stall arbitration.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int LOAD_STALL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] op_s2,
   input  logic [7:0] op_s3,
   input  logic [7:0] op_s4,
   input  logic       br_taken,
   input  logic [7:0] br_target,
   output logic       pc_en,
   output logic       pc_sel,
   output logic [7:0] pc_target,
   output logic       buf1_en,
   output logic       buf1_bubble,
   output logic       buf2_bubble,
   output logic [1:0] state,
   output logic       halted,
   output logic [7:0] stall_cnt,
   output logic [7:0] flush_cnt
);

   localparam logic [1:0] CD_LOAD = 2'(LOAD_STALL - 1);
   localparam logic       MULTI   = (LOAD_STALL > 1);

   state_e     st;
   state_e     st_nxt;
   logic [1:0] cd;
   logic [1:0] cd_nxt;
   hz_ctl_t    ctl;
   logic       active;
   logic       halt_ev;
   logic       br_ev;
   logic       ld_ev;
   logic       hold_ev;
   logic       idle_ev;
   logic       stall_inc;
   logic       flush_inc;

   // Decode opcode is visible here but no hazard
   // currently keys off it.
   logic unused_op_s2;
   assign unused_op_s2 = ^op_s2;

   // Resolve the per-cycle event priority:
   // halt beats branch beats load-use.
   always_comb begin
      active  = (st == ST_RUN) || (st == ST_STALL);
      halt_ev = active && (op_s4 == OP_HALT);
      br_ev   = active && br_taken && !halt_ev;
      ld_ev   = (st == ST_RUN) && (op_s3 == OP_LOAD)
                && !halt_ev && !br_ev;
      hold_ev = (st == ST_STALL) && !halt_ev && !br_ev;
      idle_ev = (st == ST_RUN) && !halt_ev
                && !br_ev && !ld_ev;
   end

   // Mealy control outputs and next-state selection.
   always_comb begin
      ctl       = CTL_FREEZE;
      st_nxt    = ST_RUN;
      cd_nxt    = 2'd0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (rst) begin
         ctl = CTL_RESET;
      end else begin
         unique case (1'b1)
            (st == ST_HALT): begin
               st_nxt = ST_HALT;
            end
            (st == ST_BAD): begin
               st_nxt = ST_RUN;
            end
            halt_ev: begin
               st_nxt = ST_HALT;
            end
            br_ev: begin
               ctl       = CTL_FLUSH;
               flush_inc = 1'b1;
            end
            ld_ev: begin
               stall_inc = 1'b1;
               cd_nxt    = CD_LOAD;
               st_nxt    = MULTI ? ST_STALL : ST_RUN;
            end
            hold_ev: begin
               stall_inc = 1'b1;
               if (cd > 2'd1) begin
                  cd_nxt = cd - 2'd1;
                  st_nxt = ST_STALL;
               end
            end
            idle_ev: begin
               ctl = CTL_RUN;
            end
            default: begin
               ctl = CTL_FREEZE;
            end
         endcase
      end
   end

   // State and stall countdown registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= ST_RUN;
         cd <= 2'd0;
      end else begin
         st <= st_nxt;
         cd <= cd_nxt;
      end
   end

   sat_cnt8 u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stall_inc),
      .q   (stall_cnt)
   );

   sat_cnt8 u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (flush_inc),
      .q   (flush_cnt)
   );

   assign pc_en       = ctl.pc_en;
   assign pc_sel      = ctl.pc_sel;
   assign buf1_en     = ctl.buf1_en;
   assign buf1_bubble = ctl.buf1_bubble;
   assign buf2_bubble = ctl.buf2_bubble;
   assign pc_target   = ctl.pc_sel ? br_target : 8'h00;
   assign state       = st;
   assign halted      = (st == ST_HALT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controllers with
// LOAD_STALL 1, 2, 3 share one stimulus stream.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] op_s2 = 8'h00;
   logic [7:0] op_s3 = 8'h00;
   logic [7:0] op_s4 = 8'h00;
   logic       br_taken = 1'b0;
   logic [7:0] br_target = 8'h00;

   logic       pc_en [3];
   logic       pc_sel [3];
   logic [7:0] pc_target [3];
   logic       buf1_en [3];
   logic       buf1_bubble [3];
   logic       buf2_bubble [3];
   logic [1:0] state [3];
   logic       halted [3];
   logic [7:0] stall_cnt [3];
   logic [7:0] flush_cnt [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LOAD_STALL(1)) u1 (
      .clk(clk), .rst(rst), .op_s2(op_s2),
      .op_s3(op_s3), .op_s4(op_s4),
      .br_taken(br_taken), .br_target(br_target),
      .pc_en(pc_en[0]), .pc_sel(pc_sel[0]),
      .pc_target(pc_target[0]),
      .buf1_en(buf1_en[0]),
      .buf1_bubble(buf1_bubble[0]),
      .buf2_bubble(buf2_bubble[0]),
      .state(state[0]), .halted(halted[0]),
      .stall_cnt(stall_cnt[0]),
      .flush_cnt(flush_cnt[0])
   );

   pipe_hazard_ctrl #(.LOAD_STALL(2)) u2 (
      .clk(clk), .rst(rst), .op_s2(op_s2),
      .op_s3(op_s3), .op_s4(op_s4),
      .br_taken(br_taken), .br_target(br_target),
      .pc_en(pc_en[1]), .pc_sel(pc_sel[1]),
      .pc_target(pc_target[1]),
      .buf1_en(buf1_en[1]),
      .buf1_bubble(buf1_bubble[1]),
      .buf2_bubble(buf2_bubble[1]),
      .state(state[1]), .halted(halted[1]),
      .stall_cnt(stall_cnt[1]),
      .flush_cnt(flush_cnt[1])
   );

   pipe_hazard_ctrl #(.LOAD_STALL(3)) u3 (
      .clk(clk), .rst(rst), .op_s2(op_s2),
      .op_s3(op_s3), .op_s4(op_s4),
      .br_taken(br_taken), .br_target(br_target),
      .pc_en(pc_en[2]), .pc_sel(pc_sel[2]),
      .pc_target(pc_target[2]),
      .buf1_en(buf1_en[2]),
      .buf1_bubble(buf1_bubble[2]),
      .buf2_bubble(buf2_bubble[2]),
      .state(state[2]), .halted(halted[2]),
      .stall_cnt(stall_cnt[2]),
      .flush_cnt(flush_cnt[2])
   );

   // Apply one cycle of inputs at the falling edge.
   task automatic drive(input logic [7:0] o3,
                        input logic [7:0] o4,
                        input logic bt,
                        input logic [7:0] tgt);
      @(negedge clk);
      rst       = 1'b0;
      op_s2     = 8'h11;
      op_s3     = o3;
      op_s4     = o4;
      br_taken  = bt;
      br_target = tgt;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      op_s3    = 8'h00;
      op_s4    = 8'h00;
      br_taken = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst       = 1'b1;
      op_s4     = 8'hFF;
      br_taken  = 1'b1;
      br_target = 8'h3C;
      #1;
      checks++;
      if ({pc_en[0], pc_sel[0], buf1_en[0],
           buf1_bubble[0], buf2_bubble[0]} !== 5'b00011) begin
         errors++;
         $display("FAIL rst_forced got=%b exp=00011",
            {pc_en[0], pc_sel[0], buf1_en[0],
             buf1_bubble[0], buf2_bubble[0]});
      end
      checks++;
      if (pc_target[0] !== 8'h00) begin
         errors++;
         $display("FAIL rst_target got=%h exp=00",
            pc_target[0]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if ({state[0], halted[0], stall_cnt[0],
           flush_cnt[0]} !== 19'd0) begin
         errors++;
         $display("FAIL rst_state st=%0d h=%b s=%h f=%h exp=0",
            state[0], halted[0], stall_cnt[0],
            flush_cnt[0]);
      end
      checks++;
      if ({pc_en[0], pc_sel[0], buf1_en[0],
           buf1_bubble[0], buf2_bubble[0]} !== 5'b10100) begin
         errors++;
         $display("FAIL run_idle got=%b exp=10100",
            {pc_en[0], pc_sel[0], buf1_en[0],
             buf1_bubble[0], buf2_bubble[0]});
      end
   endtask

   task automatic test_load_stall();
      do_reset();
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      checks++;
      if ({pc_en[1], buf1_en[1], buf2_bubble[1],
           state[1]} !== 5'b00100) begin
         errors++;
         $display("FAIL ld_c1 got=%b exp=00100",
            {pc_en[1], buf1_en[1], buf2_bubble[1],
             state[1]});
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[1] !== 2'd1 || stall_cnt[1] !== 8'd1
          || pc_en[1] !== 1'b0) begin
         errors++;
         $display("FAIL ld2_c2 st=%0d s=%0d pe=%b exp 1 1 0",
            state[1], stall_cnt[1], pc_en[1]);
      end
      checks++;
      if (state[0] !== 2'd0 || stall_cnt[0] !== 8'd1
          || pc_en[0] !== 1'b1) begin
         errors++;
         $display("FAIL ld1_c2 st=%0d s=%0d pe=%b exp 0 1 1",
            state[0], stall_cnt[0], pc_en[0]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[1] !== 2'd0 || stall_cnt[1] !== 8'd2
          || pc_en[1] !== 1'b1) begin
         errors++;
         $display("FAIL ld2_c3 st=%0d s=%0d pe=%b exp 0 2 1",
            state[1], stall_cnt[1], pc_en[1]);
      end
      checks++;
      if (state[2] !== 2'd1 || stall_cnt[2] !== 8'd2
          || pc_en[2] !== 1'b0) begin
         errors++;
         $display("FAIL ld3_c3 st=%0d s=%0d pe=%b exp 1 2 0",
            state[2], stall_cnt[2], pc_en[2]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd0 || stall_cnt[2] !== 8'd3
          || stall_cnt[1] !== 8'd2) begin
         errors++;
         $display("FAIL ld3_c4 st=%0d s3=%0d s2=%0d exp 0 3 2",
            state[2], stall_cnt[2], stall_cnt[1]);
      end
   endtask

   task automatic test_branch();
      do_reset();
      drive(8'h00, 8'h00, 1'b1, 8'h3C);
      checks++;
      if ({pc_en[0], pc_sel[0], buf1_en[0],
           buf1_bubble[0], buf2_bubble[0]} !== 5'b11111
          || pc_target[0] !== 8'h3C) begin
         errors++;
         $display("FAIL br_ctl got=%b tgt=%h exp=11111 3c",
            {pc_en[0], pc_sel[0], buf1_en[0],
             buf1_bubble[0], buf2_bubble[0]},
            pc_target[0]);
      end
      drive(8'h40, 8'h00, 1'b1, 8'h20);
      checks++;
      if (flush_cnt[0] !== 8'd1 || state[0] !== 2'd0) begin
         errors++;
         $display("FAIL br_cnt f=%0d st=%0d exp 1 0",
            flush_cnt[0], state[0]);
      end
      checks++;
      if (pc_en[1] !== 1'b1 || pc_sel[1] !== 1'b1
          || pc_target[1] !== 8'h20) begin
         errors++;
         $display("FAIL br_over_ld pe=%b ps=%b t=%h exp 1 1 20",
            pc_en[1], pc_sel[1], pc_target[1]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h99);
      checks++;
      if (state[1] !== 2'd0 || stall_cnt[1] !== 8'd0
          || flush_cnt[1] !== 8'd2) begin
         errors++;
         $display("FAIL br_ld_cnt st=%0d s=%0d f=%0d exp 0 0 2",
            state[1], stall_cnt[1], flush_cnt[1]);
      end
      checks++;
      if (pc_sel[0] !== 1'b0 || pc_target[0] !== 8'h00) begin
         errors++;
         $display("FAIL br_idle_tgt ps=%b t=%h exp 0 00",
            pc_sel[0], pc_target[0]);
      end
   endtask

   task automatic test_halt_priority();
      do_reset();
      drive(8'h40, 8'hFF, 1'b1, 8'h3C);
      checks++;
      if ({pc_en[0], pc_sel[0], buf1_en[0],
           buf2_bubble[0]} !== 4'b0001
          || pc_target[0] !== 8'h00) begin
         errors++;
         $display("FAIL halt_ctl got=%b t=%h exp=0001 00",
            {pc_en[0], pc_sel[0], buf1_en[0],
             buf2_bubble[0]}, pc_target[0]);
      end
      drive(8'h00, 8'h00, 1'b1, 8'h77);
      checks++;
      if (state[0] !== 2'd2 || halted[0] !== 1'b1
          || flush_cnt[0] !== 8'd0
          || stall_cnt[0] !== 8'd0) begin
         errors++;
         $display("FAIL halt_st st=%0d h=%b f=%0d s=%0d exp 2 1 0 0",
            state[0], halted[0], flush_cnt[0],
            stall_cnt[0]);
      end
      checks++;
      if (pc_en[0] !== 1'b0 || pc_sel[0] !== 1'b0
          || buf2_bubble[0] !== 1'b1) begin
         errors++;
         $display("FAIL halt_ign pe=%b ps=%b b2=%b exp 0 0 1",
            pc_en[0], pc_sel[0], buf2_bubble[0]);
      end
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd2 || flush_cnt[2] !== 8'd0
          || stall_cnt[2] !== 8'd0) begin
         errors++;
         $display("FAIL halt_hold st=%0d f=%0d s=%0d exp 2 0 0",
            state[2], flush_cnt[2], stall_cnt[2]);
      end
   endtask

   task automatic test_stall_branch();
      do_reset();
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 8'h00, 1'b1, 8'h55);
      checks++;
      if (state[2] !== 2'd1 || pc_en[2] !== 1'b1
          || pc_sel[2] !== 1'b1
          || pc_target[2] !== 8'h55) begin
         errors++;
         $display("FAIL stbr_ctl st=%0d pe=%b ps=%b t=%h exp 1 1 1 55",
            state[2], pc_en[2], pc_sel[2],
            pc_target[2]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd0 || flush_cnt[2] !== 8'd1
          || stall_cnt[2] !== 8'd1
          || pc_en[2] !== 1'b1) begin
         errors++;
         $display("FAIL stbr_nxt st=%0d f=%0d s=%0d pe=%b exp 0 1 1 1",
            state[2], flush_cnt[2], stall_cnt[2],
            pc_en[2]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd0 || stall_cnt[2] !== 8'd1) begin
         errors++;
         $display("FAIL stbr_res st=%0d s=%0d exp 0 1",
            state[2], stall_cnt[2]);
      end
      do_reset();
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 8'hFF, 1'b1, 8'h66);
      checks++;
      if (pc_en[2] !== 1'b0 || pc_sel[2] !== 1'b0) begin
         errors++;
         $display("FAIL sthalt_ctl pe=%b ps=%b exp 0 0",
            pc_en[2], pc_sel[2]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd2 || stall_cnt[2] !== 8'd1
          || flush_cnt[2] !== 8'd0) begin
         errors++;
         $display("FAIL sthalt_st st=%0d s=%0d f=%0d exp 2 1 0",
            state[2], stall_cnt[2], flush_cnt[2]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(8'h00, 8'h00, 1'b1, 8'(i));
         if (i == 254) begin
            checks++;
            if (flush_cnt[0] !== 8'hFE) begin
               errors++;
               $display("FAIL b2b_254 got=%h exp=fe",
                  flush_cnt[0]);
            end
         end
      end
      checks++;
      if (pc_target[0] !== 8'h2B) begin
         errors++;
         $display("FAIL b2b_tgt got=%h exp=2b",
            pc_target[0]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (flush_cnt[0] !== 8'hFF || flush_cnt[2] !== 8'hFF
          || state[0] !== 2'd0) begin
         errors++;
         $display("FAIL b2b_sat f1=%h f3=%h st=%0d exp ff ff 0",
            flush_cnt[0], flush_cnt[2], state[0]);
      end
   endtask

   task automatic test_rst_recover();
      do_reset();
      drive(8'h00, 8'h00, 1'b1, 8'h10);
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 8'hFF, 1'b0, 8'h00);
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (halted[0] !== 1'b1 || flush_cnt[0] !== 8'd1
          || stall_cnt[0] !== 8'd1) begin
         errors++;
         $display("FAIL pre_rst h=%b f=%0d s=%0d exp 1 1 1",
            halted[0], flush_cnt[0], stall_cnt[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (pc_en[0] !== 1'b0 || buf1_bubble[0] !== 1'b1) begin
         errors++;
         $display("FAIL rsthalt_forced pe=%b b1=%b exp 0 1",
            pc_en[0], buf1_bubble[0]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[0] !== 2'd0 || halted[0] !== 1'b0
          || stall_cnt[0] !== 8'd0
          || flush_cnt[0] !== 8'd0
          || pc_en[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_halt st=%0d h=%b s=%0d f=%0d pe=%b exp 0 0 0 0 1",
            state[0], halted[0], stall_cnt[0],
            flush_cnt[0], pc_en[0]);
      end
      drive(8'h40, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      rst   = 1'b1;
      op_s3 = 8'h00;
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd0 || pc_en[2] !== 1'b1
          || stall_cnt[2] !== 8'd0) begin
         errors++;
         $display("FAIL rst_stall st=%0d pe=%b s=%0d exp 0 1 0",
            state[2], pc_en[2], stall_cnt[2]);
      end
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      checks++;
      if (state[2] !== 2'd0 || pc_en[2] !== 1'b1) begin
         errors++;
         $display("FAIL rst_stall_res st=%0d pe=%b exp 0 1",
            state[2], pc_en[2]);
      end
   endtask

   initial begin
      test_reset();
      test_load_stall();
      test_branch();
      test_halt_priority();
      test_stall_branch();
      test_back_to_back();
      test_rst_recover();
      $display("Result: errors=%0d of %0d checks",
         errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 1, meaning load-use stall length in cycles, legal range 1..3.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port op_s2  in  8  opcode held in stage-1/2 buffer (decode stage).
REQ-005 SHALL have port op_s3  in  8  opcode held in stage-2/3 buffer (ALU stage).
REQ-006 SHALL have port op_s4  in  8  opcode held in stage-3/4 buffer (writeback stage).
REQ-007 SHALL have port br_taken  in  1  stage-3 branch/jump resolved taken this cycle.
REQ-008 SHALL have port br_target  in  8  stage-3 branch target PC.
REQ-009 SHALL have port pc_en  out  1  PC register load enable.
REQ-010 SHALL have port pc_sel  out  1  1 = PC loads pc_target, 0 = PC loads PC+1.
REQ-011 SHALL have port pc_target  out  8  redirect PC value.
REQ-012 SHALL have port buf1_en  out  1  stage-1/2 buffer load enable (0 = hold).
REQ-013 SHALL have port buf1_bubble  out  1  stage-1/2 buffer loads OP_NOP instead of fetched opcode.
REQ-014 SHALL have port buf2_bubble  out  1  stage-2/3 buffer loads OP_NOP instead of op_s2.
REQ-015 SHALL have port state  out  2  current FSM state encoding.
REQ-016 SHALL have port halted  out  1  processor frozen by HALT.
REQ-017 SHALL have ports stall_cnt and flush_cnt  out  8 each  saturating event counters.

Function
REQ-018 SHALL implement FSM states RUN=2'd0, STALL=2'd1, HALT=2'd2; 2'd3 unreachable, decodes to RUN next cycle.
REQ-019 SHALL drive outputs combinationally from registered state plus current inputs (Mealy); state, counters and stall countdown registered.
REQ-020 SHALL, in RUN with no event, drive pc_en=1, pc_sel=0, buf1_en=1, both bubbles 0.
REQ-021 SHALL apply per-cycle priority in RUN: HALT detect > branch flush > load-use stall.
REQ-022 SHALL, in RUN with op_s4==OP_HALT, drive pc_en=0, buf1_en=0, buf2_bubble=1, and enter HALT next cycle.
REQ-023 SHALL, in RUN with br_taken=1, drive pc_en=1, pc_sel=1, pc_target=br_target, buf1_bubble=1, buf2_bubble=1, increment flush_cnt, remain in RUN (single-cycle flush).
REQ-024 SHALL, in RUN with op_s3==OP_LOAD, drive pc_en=0, buf1_en=0, buf2_bubble=1, increment stall_cnt, load countdown with LOAD_STALL-1, enter STALL if LOAD_STALL>1 else remain RUN.
REQ-025 SHALL, in STALL, hold pc_en=0, buf1_en=0, buf2_bubble=1, increment stall_cnt each cycle, decrement countdown, return to RUN after the cycle in which countdown is 1.
REQ-026 SHALL, in STALL, obey br_taken and HALT detect with RUN priorities; either aborts the stall (countdown cleared).
REQ-027 SHALL, in HALT, drive pc_en=0, buf1_en=0, buf2_bubble=1, halted=1, ignore all inputs until rst.
REQ-028 SHALL saturate stall_cnt and flush_cnt at 8'hFF (no wrap).
REQ-029 SHALL drive pc_target=br_target whenever pc_sel=1, else 8'h00.

Reset
REQ-030 SHALL, on rst sampled high, set state=RUN, countdown=0, stall_cnt=0, flush_cnt=0, halted=0 at that edge.
REQ-031 SHALL, while rst high, force pc_en=0, pc_sel=0, buf1_en=0, buf1_bubble=1, buf2_bubble=1 regardless of state.
REQ-032 SHALL allow rst mid-STALL or in HALT to return to RUN with no residual countdown.

Structure
REQ-033 SHALL take OP_NOP=8'h00, OP_LOAD=8'h40, OP_HALT=8'hFF and state encodings from shared package pipe_pkg.
REQ-034 SHALL contain one sub-module sat_cnt8 (8-bit saturating counter with inc and sync clear), instanced twice.

Verification
REQ-035 SHALL test: op_s3=8'h40, LOAD_STALL=2 -> pc_en=0 two cycles, stall_cnt 0->2, state RUN->STALL->RUN.
REQ-036 SHALL test: br_taken=1, br_target=8'h3C -> same cycle pc_sel=1, pc_target=8'h3C, both bubbles 1, flush_cnt=1.
REQ-037 SHALL test: op_s4=8'hFF with br_taken=1 same cycle -> pc_en=0, pc_sel=0, next state HALT, flush_cnt unchanged.
REQ-038 SHALL test: br_taken=1 during STALL cycle 2 (LOAD_STALL=3) -> redirect taken, state RUN next cycle.
REQ-039 SHALL test: 300 back-to-back branch flushes -> flush_cnt holds 8'hFF.
REQ-040 SHALL test: rst pulse while halted=1 -> next cycle state=RUN, halted=0, counters 0, pc_en=1.
